// File: rtl/mul16_pkg.sv
// Shared types and constants for the mul16 engine and its Booth multiplier.
package mul16_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL,
    STORE,
    DONE
  } state_t;

  localparam int unsigned BYTES_PER_OP    = 2;
  localparam int unsigned BYTES_PER_PROD  = 4;
  localparam int unsigned MUL_STEPS       = 16;
  localparam int unsigned CYCLES_PER_PAIR = 2 * BYTES_PER_OP + MUL_STEPS + BYTES_PER_PROD;

endpackage

// File: rtl/booth_mul16.sv
// 16-cycle radix-2 Booth multiplier, signed 16x16 -> 32.
module booth_mul16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] product
);

  logic [16:0] mcand;
  logic [16:0] acc;
  logic [15:0] mplier;
  logic        q_1;
  logic [16:0] sum;

  // 17-bit multiplicand keeps acc - (-32768) representable
  always_comb begin
    sum = acc;
    case ({mplier[0], q_1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      q_1    <= 1'b0;
    end else if (load) begin
      mcand  <= {b[15], b};
      acc    <= '0;
      mplier <= a;
      q_1    <= 1'b0;
    end else if (step) begin
      {acc, mplier, q_1} <= {sum[16], sum, mplier};
    end
  end

  assign product = {acc[15:0], mplier};

endmodule

// File: rtl/mul16_engine.sv
// Start/done responder: reads operand pairs from byte memory, Booth-multiplies
// each pair and writes the 32-bit products back big-endian.
module mul16_engine
  import mul16_pkg::*;
#(
  parameter int NUM_PAIRS = 16,
  parameter int OP_BASE   = 0,
  parameter int PROD_BASE = 64,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data
);

  localparam int PAIR_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int CNT_W  = $clog2(CYCLES_PER_PAIR);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [PAIR_W-1:0]  pair;
  logic               armed;
  logic               go;
  logic [23:0]        op_buf;
  logic               mul_load, mul_step;
  logic [31:0]        product;

  booth_mul16 u_booth (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (mul_load),
    .step    (mul_step),
    .a       (op_buf[23:8]),
    .b       ({op_buf[7:0], mem_rd_data}),
    .product (product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // start=1 in any busy state aborts; the write strobe is gated so the abort edge writes nothing
  always_comb begin
    state_next  = state;
    go          = (state == IDLE) && armed && !start;
    busy        = 1'b0;
    mul_load    = 1'b0;
    mul_step    = 1'b0;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (state)
      IDLE: if (go) state_next = LOAD;
      LOAD: begin
        busy     = 1'b1;
        mem_addr = ADDR_W'(OP_BASE + int'(pair) * int'(2 * BYTES_PER_OP) + int'(cnt));
        if (start) state_next = IDLE;
        else if (cnt == CNT_W'(2 * BYTES_PER_OP - 1)) begin
          mul_load   = 1'b1;
          state_next = MUL;
        end
      end
      MUL: begin
        busy = 1'b1;
        if (start) state_next = IDLE;
        else begin
          mul_step = 1'b1;
          if (cnt == CNT_W'(MUL_STEPS - 1)) state_next = STORE;
        end
      end
      STORE: begin
        busy      = 1'b1;
        mem_addr  = ADDR_W'(PROD_BASE + int'(pair) * int'(BYTES_PER_PROD) + int'(cnt));
        mem_wr_en = !start;
        case (cnt[1:0])
          2'd0:    mem_wr_data = product[31:24];
          2'd1:    mem_wr_data = product[23:16];
          2'd2:    mem_wr_data = product[15:8];
          default: mem_wr_data = product[7:0];
        endcase
        if (start) state_next = IDLE;
        else if (cnt == CNT_W'(BYTES_PER_PROD - 1))
          state_next = (pair == PAIR_W'(NUM_PAIRS - 1)) ? DONE : LOAD;
      end
      DONE: if (start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // done is registered from DONE so it rises one edge after the run's final write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed  <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      pair   <= '0;
      op_buf <= '0;
    end else begin
      if (start)   armed <= 1'b1;
      else if (go) armed <= 1'b0;
      done <= (state == DONE) && !start;
      if (state_next != state) cnt <= '0;
      else if (busy)           cnt <= cnt + 1'b1;
      if (go) pair <= '0;
      else if (state == STORE && state_next == LOAD) pair <= pair + 1'b1;
      if (state == LOAD) op_buf <= {op_buf[15:0], mem_rd_data};
    end
  end

endmodule

// File: tb/tb_mul16_engine.sv
// Directed and randomized bench for mul16_engine with a byte memory model.
module tb_mul16_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       done, busy, mem_wr_en;
  logic [7:0] mem_addr, mem_rd_data, mem_wr_data;

  logic [7:0]  op_mem [256];
  logic [7:0]  wr_mem [256];
  logic [15:0] ops [32];
  logic        clr = 1'b0;
  int          wr_count = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mul16_engine #(.NUM_PAIRS(16), .OP_BASE(0), .PROD_BASE(64), .ADDR_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .done        (done),
    .busy        (busy),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data)
  );

  assign mem_rd_data = op_mem[mem_addr];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) wr_mem[i] <= 8'hAA;
    end else if (mem_wr_en) begin
      wr_mem[mem_addr] <= mem_wr_data;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] prod(input int j);
    return {wr_mem[64+4*j], wr_mem[65+4*j], wr_mem[66+4*j], wr_mem[67+4*j]};
  endfunction

  task automatic load_ops();
    for (int i = 0; i < 32; i++) begin
      op_mem[2*i]   = ops[i][15:8];
      op_mem[2*i+1] = ops[i][7:0];
    end
  endtask

  task automatic random_ops();
    for (int i = 0; i < 32; i++) ops[i] = 16'($urandom);
    load_ops();
  endtask

  task automatic clear_prod();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic go_run();
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string tag);
    int lat = 0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && lat < 500) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd385);
  endtask

  task automatic check_model(input string tag, input int n);
    for (int j = 0; j < n; j++) begin
      logic signed [31:0] r;
      r = $signed(ops[2*j]) * $signed(ops[2*j+1]);
      check($sformatf("%s_p%0d", tag, j), prod(j), r);
    end
  endtask

  task automatic release_start(input string tag);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_done_clr"}, 32'(done), 32'd0);
  endtask

  task automatic full_run(input string tag);
    int w0;
    clear_prod();
    w0 = wr_count;
    go_run();
    wait_done(tag);
    check({tag, "_writes"}, 32'(wr_count - w0), 32'd64);
    check_model(tag, 16);
    release_start(tag);
  endtask

  task automatic abort_at(input string tag, input int n, input int exp_writes);
    int w0, w1;
    clear_prod();
    w0 = wr_count;
    go_run();
    repeat (n) @(posedge clk);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_writes"}, 32'(wr_count - w0), 32'(exp_writes));
    w1 = wr_count;
    repeat (40) @(posedge clk); #1;
    check({tag, "_no_more_writes"}, 32'(wr_count - w1), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
    check({tag, "_addr"},  32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wr_data), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_dir [5];
    for (int i = 0; i < 256; i++) op_mem[i] = 8'h00;
    for (int i = 0; i < 32; i++) ops[i] = 16'h0000;

    // reset, then start held low across release must not launch a run
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_arm_busy", 32'(busy), 32'd0);
    check("no_arm_done", 32'(done), 32'd0);
    check("no_arm_writes", 32'(wr_count), 32'd0);

    // directed pairs with hand-computed products
    ops[0] = 16'hFFFB; ops[1] = 16'h0003;
    ops[2] = 16'h8000; ops[3] = 16'h8000;
    ops[4] = 16'h7FFF; ops[5] = 16'h7FFF;
    ops[6] = 16'h0000; ops[7] = 16'hFB2E;
    ops[8] = 16'hFFFF; ops[9] = 16'h0001;
    load_ops();
    exp_dir[0] = 32'hFFFF_FFF1;
    exp_dir[1] = 32'h4000_0000;
    exp_dir[2] = 32'h3FFF_0001;
    exp_dir[3] = 32'h0000_0000;
    exp_dir[4] = 32'hFFFF_FFFF;
    clear_prod();
    go_run();
    wait_done("dir");
    for (int j = 0; j < 5; j++) check($sformatf("dir_p%0d", j), prod(j), exp_dir[j]);
    for (int j = 5; j < 16; j++) check($sformatf("dir_zero_p%0d", j), prod(j), 32'h0);
    check("dir_byte64", 32'(wr_mem[64]), 32'hFF);
    check("dir_byte67", 32'(wr_mem[67]), 32'hF1);
    release_start("dir");

    for (int r = 0; r < 10; r++) begin
      random_ops();
      full_run($sformatf("rnd%0d", r));
    end

    // abort during the second STORE byte of pair 0: that byte must not land
    random_ops();
    abort_at("abort_store", 21, 1);
    check("abort_store_b0", 32'(wr_mem[64]), 32'(prod(0) >> 24));
    begin
      logic signed [31:0] r0;
      r0 = $signed(ops[0]) * $signed(ops[1]);
      check("abort_store_b0_val", 32'(wr_mem[64]), 32'(r0[31:24]));
    end
    check("abort_store_b1", 32'(wr_mem[65]), 32'hAA);

    // abort at cycle 100: pairs 0..3 written, pair 4 untouched, then a clean rerun
    random_ops();
    abort_at("abort100", 100, 16);
    check_model("abort100", 4);
    check("abort100_p4", prod(4), 32'hAAAA_AAAA);
    full_run("rerun");

    // reset during MUL of pair 5
    random_ops();
    clear_prod();
    go_run();
    repeat (130) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("midrst_no_run", 32'(busy), 32'd0);
    check("midrst_no_done", 32'(done), 32'd0);
    full_run("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul16_engine.md
Name: mul16_engine

Overview:
- Hardware responder for the program-3 start/done handshake.
- On a start request it reads 16 pairs of 16-bit two's-complement operands from byte-wide data memory and multiplies each pair with a sequential radix-2 Booth multiplier.
- It writes each 32-bit product back to data memory big-endian, then acknowledges with done.
- It sits beside data_mem in top_level and is the memory master while busy.

Parameters:
- NUM_PAIRS, 16, operand pairs per run
- OP_BASE, 0, byte address of operand 0
- PROD_BASE, 64, byte address of product 0
- ADDR_W, 8, memory address width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request from host; high = hold/rearm, falling edge = go
- done  out  1  acknowledge; high after last product written
- busy  out  1  high while a run is in progress
- mem_addr  out  ADDR_W  byte address
- mem_rd_data  in  8  combinational read data for mem_addr (same cycle)
- mem_wr_en  out  1  synchronous byte write strobe
- mem_wr_data  out  8  write byte

Behaviour:
- Reset values: done=0, busy=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, state=IDLE, armed=0.
- Operand layout: operand i = {mem[OP_BASE+2i], mem[OP_BASE+2i+1]}, high byte first.
- Pair j multiplies op[2j+1] * op[2j].
- Product j is written to PROD_BASE+4j .. +3, MSB first.
- Handshake:
  - armed is set on any edge sampling start=1.
  - A run begins on the first edge sampling start=0 while armed; that edge clears armed.
  - done stays high until an edge samples start=1, which clears done and sets armed.
- States:
  - IDLE -> LOAD on go.
  - LOAD: 4 cycles; reads addresses OP_BASE+4j+0..3 in order; captures A=op[2j], B=op[2j+1].
  - MUL: 16 cycles of Booth recoding on bits of A, with a 17-bit sign-extended B to accumulate and a 33-bit arithmetic-right-shift product register.
  - STORE: 4 cycles with mem_wr_en=1; bytes P[31:24], P[23:16], P[15:8], P[7:0] go to PROD_BASE+4j+0..3.
  - STORE then goes to LOAD of pair j+1, or to DONE after pair NUM_PAIRS-1.
  - DONE: done=1, busy=0; -> IDLE on start=1.
- Latency: 24 cycles per pair. done rises 16*24+1 = 385 edges after the go edge.
- busy=1 from the go edge through the last STORE cycle.
- Width rules:
  - Results are exact for every 16x16 signed pair.
  - -32768 * -32768 = 0x40000000; the 17-bit multiplicand prevents overflow on the subtract step.
  - No saturation.
- mem_wr_en is never high outside STORE.
- mem_addr wraps modulo 2^ADDR_W. Address overlap of operand and product regions is not checked.
- start=1 mid-run (LOAD/MUL/STORE): abort on that edge.
  - Go to IDLE with armed=1, busy=0, done=0.
  - Any write on that edge is suppressed.
  - Products already written remain in memory.
- rst_n low at any time: immediate return to reset values; a partial run is abandoned.
- start held low after done: no new run until start returns high and falls again.

Decomposition:
- Package mul16_pkg holds:
  - state enum (IDLE, LOAD, MUL, STORE, DONE)
  - BYTES_PER_OP=2, BYTES_PER_PROD=4, MUL_STEPS=16
  - cycles-per-pair constant (24)
- Sub-module booth_mul16: load / step / result interface; 16-cycle signed sequential multiplier; reusable by the CPU datapath.
- mul16_engine owns the handshake FSM, address counters and the byte mux.

Test Plan:
- mem[0..3] = FFFB 0003 (A=-5, B=3), start 1->0 -> mem[64..67] = FF FF FF F1; done high exactly 385 cycles after go.
- Pairs (-32768, -32768), (32767, 32767), (0, -1234), (-1, 1) -> products 0x40000000, 0x3FFF0001, 0x00000000, 0xFFFFFFFF at their 4-byte slots.
- Random 32 operands ×10 runs, with a full start 1->0 cycle and a new memory image each run -> all 16 products match a signed reference model; done clears within 1 edge of start=1.
- start raised at cycle 100 of a run -> busy=0 and done=0 next edge; no writes after that edge; re-dropping start -> full correct run.
- rst_n pulsed low during MUL of pair 5 -> outputs at reset values immediately; no run until start goes 1 then 0.
- start held low across reset release without a prior high -> no run; done remains 0.
